// File: rtl/famicom_pad_if.sv
// Famicom controller link between the host shell and the pad responder.
interface famicom_pad_if;
  localparam int unsigned BTN_W = 8;
  localparam int unsigned IDX_W = 4;

  logic [BTN_W-1:0] buttons;
  logic             famicom_latch;
  logic             famicom_pulse;
  logic             famicom_data;
  logic [IDX_W-1:0] bit_index;
  logic             frame_done;

  modport master (
    output buttons,
    output famicom_latch,
    output famicom_pulse,
    input  famicom_data,
    input  bit_index,
    input  frame_done
  );

  modport slave (
    input  buttons,
    input  famicom_latch,
    input  famicom_pulse,
    output famicom_data,
    output bit_index,
    output frame_done
  );
endinterface

// File: rtl/famicom_pad_responder.sv
// Device end of the Famicom pad link: emulates a 4021-style 8-button shift register
// clocked on clk_sys, with latch/pulse resynchronized from the host clock domain.
module famicom_pad_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        FILL_BIT    = 1'b0
) (
  input logic         clk_sys,
  input logic         reset_n,
  famicom_pad_if.slave pad
);

  localparam int unsigned SR_W  = 8;
  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SR_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] latch_meta, pulse_meta;
  logic                   latch_prev, pulse_prev;
  logic [SR_W-1:0]        sr, sr_next;
  logic [IDX_W-1:0]       bit_index_q, bit_index_next;
  logic                   frame_done_q, frame_done_next;

  logic latch_sync, pulse_sync, latch_fall, pulse_rise;

  assign latch_sync = latch_meta[SYNC_STAGES-1];
  assign pulse_sync = pulse_meta[SYNC_STAGES-1];
  assign latch_fall = ~latch_sync & latch_prev;
  assign pulse_rise = pulse_sync & ~pulse_prev;

  assign pad.famicom_data = sr[0];
  assign pad.bit_index    = bit_index_q;
  assign pad.frame_done   = frame_done_q;

  // Synchronizers plus one delayed copy for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      latch_meta <= '0;
      pulse_meta <= '0;
      latch_prev <= 1'b0;
      pulse_prev <= 1'b0;
    end else begin
      latch_meta <= {latch_meta[SYNC_STAGES-2:0], pad.famicom_latch};
      pulse_meta <= {pulse_meta[SYNC_STAGES-2:0], pad.famicom_pulse};
      latch_prev <= latch_sync;
      pulse_prev <= pulse_sync;
    end
  end

  // State, shift register and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sr           <= '1;
      bit_index_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      sr           <= sr_next;
      bit_index_q  <= bit_index_next;
      frame_done_q <= frame_done_next;
    end
  end

  // A high latch overrides everything: the part sits in parallel-load mode
  always_comb begin
    state_next      = state;
    sr_next         = sr;
    bit_index_next  = bit_index_q;
    frame_done_next = 1'b0;
    if (latch_sync) begin
      state_next     = LOAD;
      sr_next        = ~pad.buttons;
      bit_index_next = '0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          // A pulse edge coincident with the latch fall is dropped here
          if (latch_fall) state_next = SHIFT;
          bit_index_next = '0;
        end
        SHIFT: begin
          if (pulse_rise) begin
            sr_next        = {FILL_BIT, sr[SR_W-1:1]};
            bit_index_next = bit_index_q + IDX_W'(1);
            if (bit_index_q == LAST_IDX) begin
              frame_done_next = 1'b1;
              state_next      = DONE;
            end
          end
        end
        DONE: begin
          if (pulse_rise) sr_next = {FILL_BIT, sr[SR_W-1:1]};
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
